// File: rtl/hazard_ctrl_param.sv
// Parametrised ID/EX hazard controller: timed load-use/RAW stalls,
// multi-cycle mispredict flushes and saturating stall/flush statistics.
module hazard_ctrl_param #(
    parameter int NUM_SRC   = 2,
    parameter int REG_W     = 5,
    parameter int LOAD_LAT  = 1,
    parameter int RAW_LAT   = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]       id_src_use,
    input  logic                     ex_wr_en,
    input  logic [REG_W-1:0]         ex_wr_addr,
    input  logic                     ex_is_load,
    input  logic                     fwd_en,
    input  logic                     br_resolve,
    input  logic                     br_mispredict,
    input  logic                     clr_stats,
    output logic                     resolved,
    output logic                     pc_freeze,
    output logic                     id_ex_bubble,
    output logic                     do_flush,
    output logic [1:0]               state,
    output logic [15:0]              stall_cycles,
    output logic [7:0]               flush_events
);

    localparam int MAX_LR  = (LOAD_LAT > RAW_LAT) ? LOAD_LAT : RAW_LAT;
    localparam int MAX_LAT = (MAX_LR > FLUSH_CYC) ? MAX_LR : FLUSH_CYC;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] LOAD_INIT  = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] RAW_INIT   = CNT_W'(RAW_LAT - 1);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        NORM   = 2'b00,
        LSTALL = 2'b01,
        RSTALL = 2'b10,
        FLUSH  = 2'b11
    } state_t;

    state_t           cur_st;
    state_t           nxt_st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [REG_W-1:0] src;
    logic             any_match;
    logic             load_haz;
    logic             raw_haz;
    logic             mispred;
    logic             in_stall;

    always_comb begin
        any_match = 1'b0;
        src       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src = id_src_addr[i*REG_W +: REG_W];
            if (id_valid && id_src_use[i] && ex_wr_en &&
                (src != '0) && (src == ex_wr_addr))
                any_match = 1'b1;
        end
    end

    assign load_haz = any_match & ex_is_load;
    assign raw_haz  = any_match & ~fwd_en & ~ex_is_load;
    assign mispred  = br_resolve & br_mispredict;
    assign in_stall = (cur_st == LSTALL) || (cur_st == RSTALL);

    // Mispredict wins from every state, including a restart inside FLUSH.
    always_comb begin
        nxt_st  = cur_st;
        cnt_nxt = cnt;
        if (mispred) begin
            nxt_st  = FLUSH;
            cnt_nxt = FLUSH_INIT;
        end else begin
            case (cur_st)
                NORM: begin
                    if (load_haz) begin
                        nxt_st  = LSTALL;
                        cnt_nxt = LOAD_INIT;
                    end else if (raw_haz) begin
                        nxt_st  = RSTALL;
                        cnt_nxt = RAW_INIT;
                    end
                end
                default: begin
                    if (cnt == '0)
                        nxt_st = NORM;
                    else
                        cnt_nxt = cnt - 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st <= NORM;
            cnt    <= '0;
        end else begin
            cur_st <= nxt_st;
            cnt    <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (in_stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (mispred && (flush_events != 8'hFF))
                flush_events <= flush_events + 8'd1;
        end
    end

    always_comb begin
        resolved     = 1'b0;
        pc_freeze    = 1'b0;
        id_ex_bubble = 1'b0;
        do_flush     = 1'b0;
        unique case (1'b1)
            (cur_st == NORM):  resolved = 1'b1;
            in_stall: begin
                pc_freeze    = 1'b1;
                id_ex_bubble = 1'b1;
            end
            (cur_st == FLUSH): begin
                pc_freeze = 1'b1;
                do_flush  = 1'b1;
            end
            default: resolved = 1'b1;
        endcase
    end

    assign state = cur_st;

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Scoreboard bench for hazard_ctrl_param: two parameterisations share one
// stimulus stream, checked against a residency-based reference model.
module tb_hazard_ctrl_param;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_use;
    logic        ex_wr_en;
    logic [4:0]  ex_wr_addr;
    logic        ex_is_load;
    logic        fwd_en;
    logic        br_resolve;
    logic        br_mispredict;
    logic        clr_stats;

    logic        res_a, frz_a, bub_a, fl_a;
    logic [1:0]  st_a;
    logic [15:0] sc_a;
    logic [7:0]  fe_a;
    logic        res_b, frz_b, bub_b, fl_b;
    logic [1:0]  st_b;
    logic [15:0] sc_b;
    logic [7:0]  fe_b;

    hazard_ctrl_param dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src_addr(id_src_addr), .id_src_use(id_src_use),
        .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
        .ex_is_load(ex_is_load), .fwd_en(fwd_en),
        .br_resolve(br_resolve), .br_mispredict(br_mispredict),
        .clr_stats(clr_stats), .resolved(res_a), .pc_freeze(frz_a),
        .id_ex_bubble(bub_a), .do_flush(fl_a), .state(st_a),
        .stall_cycles(sc_a), .flush_events(fe_a)
    );

    hazard_ctrl_param #(.LOAD_LAT(3), .RAW_LAT(200), .FLUSH_CYC(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src_addr(id_src_addr), .id_src_use(id_src_use),
        .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
        .ex_is_load(ex_is_load), .fwd_en(fwd_en),
        .br_resolve(br_resolve), .br_mispredict(br_mispredict),
        .clr_stats(clr_stats), .resolved(res_b), .pc_freeze(frz_b),
        .id_ex_bubble(bub_b), .do_flush(fl_b), .state(st_b),
        .stall_cycles(sc_b), .flush_events(fe_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 none, 1 load stall, 2 raw stall, 3 flush; left = cycles remaining
    typedef struct {
        int kind;
        int left;
        int stalls;
        int flushes;
    } mst_t;

    typedef struct packed {
        logic [29:0] a;
        logic [29:0] b;
    } exp_t;

    exp_t q[$];
    mst_t ma, mb;
    int   ncmp  = 0;
    int   nfail = 0;

    function automatic mst_t step(mst_t s, logic rst, logic lh, logic rh,
                                  logic mp, logic clr, int ll, int rl, int fc);
        mst_t n;
        logic stalling;
        n = s;
        if (!rst) begin
            n = '{0, 0, 0, 0};
            return n;
        end
        stalling = (s.kind == 1) || (s.kind == 2);
        if (mp) begin
            n.kind = 3;
            n.left = fc;
        end else if (s.kind != 0) begin
            n.left = s.left - 1;
            if (n.left == 0) n.kind = 0;
        end else if (lh) begin
            n.kind = 1;
            n.left = ll;
        end else if (rh) begin
            n.kind = 2;
            n.left = rl;
        end
        if (clr) begin
            n.stalls  = 0;
            n.flushes = 0;
        end else begin
            if (stalling && s.stalls < 65535) n.stalls = s.stalls + 1;
            if (mp && s.flushes < 255) n.flushes = s.flushes + 1;
        end
        return n;
    endfunction

    function automatic logic [29:0] exp_vec(mst_t s);
        logic [1:0]  k;
        logic [15:0] sc;
        logic [7:0]  fe;
        k  = 2'(s.kind);
        sc = 16'(s.stalls);
        fe = 8'(s.flushes);
        return {k, s.kind == 0, s.kind != 0,
                (s.kind == 1) || (s.kind == 2), s.kind == 3, sc, fe};
    endfunction

    function automatic logic hit();
        logic h;
        h = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (id_valid && id_src_use[i] && ex_wr_en &&
                id_src_addr[i*5 +: 5] != 5'd0 &&
                id_src_addr[i*5 +: 5] == ex_wr_addr)
                h = 1'b1;
        end
        return h;
    endfunction

    task automatic tick();
        logic h, lh, rh, mp;
        h  = hit();
        lh = h && ex_is_load;
        rh = h && !fwd_en && !ex_is_load;
        mp = br_resolve && br_mispredict;
        ma = step(ma, rst_n, lh, rh, mp, clr_stats, 1, 2, 2);
        mb = step(mb, rst_n, lh, rh, mp, clr_stats, 3, 200, 2);
        q.push_back('{a: exp_vec(ma), b: exp_vec(mb)});
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst_n = 1'b1; id_valid = 1'b0; id_src_addr = '0; id_src_use = '0;
        ex_wr_en = 1'b0; ex_wr_addr = '0; ex_is_load = 1'b0; fwd_en = 1'b1;
        br_resolve = 1'b0; br_mispredict = 1'b0; clr_stats = 1'b0;
    endtask

    task automatic idle(int n);
        set_idle();
        repeat (n) tick();
    endtask

    task automatic hazard(logic [4:0] s0, logic [4:0] s1, logic [1:0] use_,
                          logic [4:0] wa, logic ld, logic fe);
        id_valid = 1'b1; id_src_addr = {s1, s0}; id_src_use = use_;
        ex_wr_en = 1'b1; ex_wr_addr = wa; ex_is_load = ld; fwd_en = fe;
    endtask

    task automatic mispredict();
        set_idle();
        br_resolve = 1'b1; br_mispredict = 1'b1;
        tick();
    endtask

    // Monitor: every presented output cycle is compared with the oldest entry.
    always begin
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            ncmp += 2;
            if ({st_a, res_a, frz_a, bub_a, fl_a, sc_a, fe_a} !== e.a) begin
                nfail++;
                if (nfail <= 20)
                    $display("FAIL dut_a t=%0t got=%h want=%h", $time,
                             {st_a, res_a, frz_a, bub_a, fl_a, sc_a, fe_a}, e.a);
            end
            if ({st_b, res_b, frz_b, bub_b, fl_b, sc_b, fe_b} !== e.b) begin
                nfail++;
                if (nfail <= 20)
                    $display("FAIL dut_b t=%0t got=%h want=%h", $time,
                             {st_b, res_b, frz_b, bub_b, fl_b, sc_b, fe_b}, e.b);
            end
        end
    end

    initial begin
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        set_idle();
        rst_n = 1'b0;
        repeat (2) tick();
        idle(3);

        // load-use, single operand
        hazard(5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
        tick();
        idle(5);

        // RAW without forwarding, then with forwarding
        hazard(5'd0, 5'd7, 2'b10, 5'd7, 1'b0, 1'b0);
        tick();
        mispredict();
        idle(4);
        hazard(5'd0, 5'd7, 2'b10, 5'd7, 1'b0, 1'b1);
        tick();
        idle(4);

        // register zero and qualifiers
        hazard(5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b0);
        tick();
        hazard(5'd9, 5'd9, 2'b00, 5'd9, 1'b1, 1'b0);
        tick();
        hazard(5'd9, 5'd9, 2'b11, 5'd9, 1'b0, 1'b0);
        id_valid = 1'b0;
        tick();
        idle(3);

        // mispredict during load stall, single then restarted
        clr_stats = 1'b1;
        tick();
        hazard(5'd4, 5'd4, 2'b11, 5'd4, 1'b1, 1'b1);
        tick();
        idle(1);
        mispredict();
        idle(5);
        hazard(5'd4, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1);
        tick();
        idle(1);
        mispredict();
        mispredict();
        idle(5);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom % 500) != 0;
            id_valid      = ($urandom % 4) != 0;
            id_src_addr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_src_use    = 2'($urandom);
            ex_wr_en      = 1'($urandom);
            ex_wr_addr    = 5'($urandom_range(0, 3));
            ex_is_load    = 1'($urandom);
            fwd_en        = 1'($urandom);
            br_resolve    = ($urandom % 8) == 0;
            br_mispredict = 1'($urandom);
            clr_stats     = ($urandom % 64) == 0;
            tick();
        end
        mispredict();
        idle(4);

        // clear during a stall leaves stall length intact
        hazard(5'd3, 5'd0, 2'b01, 5'd3, 1'b0, 1'b0);
        tick();
        set_idle();
        clr_stats = 1'b1;
        tick();
        idle(6);
        mispredict();
        idle(4);

        // persistent RAW hazard drives dut_b stall counter into saturation
        hazard(5'd6, 5'd6, 2'b11, 5'd6, 1'b0, 1'b0);
        repeat (66000) tick();
        mispredict();
        idle(4);

        set_idle();
        repeat (3) @(posedge clk);
        #2;
        ncmp++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
